// File: rtl/vga_pkg.sv
// Shared constants for the VGA timing generator: default 640x480@60 timing,
// RGB332 field positions, the pipeline tag record and colour helpers.
package vga_pkg;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FRONT  = 16;
  localparam int unsigned DEF_H_PULSE  = 96;
  localparam int unsigned DEF_H_BACK   = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FRONT  = 10;
  localparam int unsigned DEF_V_PULSE  = 2;
  localparam int unsigned DEF_V_BACK   = 33;

  localparam int unsigned RGB_R_HI = 7;
  localparam int unsigned RGB_R_LO = 5;
  localparam int unsigned RGB_G_HI = 4;
  localparam int unsigned RGB_G_LO = 2;
  localparam int unsigned RGB_B_HI = 1;
  localparam int unsigned RGB_B_LO = 0;

  // Bar 0 sits in the least significant byte.
  localparam logic [63:0] BAR_COLORS = {8'h00, 8'h03, 8'hE0, 8'hE3,
                                        8'h1C, 8'h1F, 8'hFC, 8'hFF};

  typedef struct packed {
    logic hs;
    logic vs;
    logic valid;
    logic x0;
    logic y0;
  } vga_pipe_t;

  localparam vga_pipe_t PIPE_IDLE = 5'b00000;

  function automatic logic [23:0] rgb332_expand(input logic [7:0] c);
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
    r = c[RGB_R_HI:RGB_R_LO];
    g = c[RGB_G_HI:RGB_G_LO];
    b = c[RGB_B_HI:RGB_B_LO];
    return {r, r, r[2:1], g, g, g[2:1], b, b, b, b};
  endfunction

  function automatic logic [7:0] bar_color(input logic [2:0] idx);
    return BAR_COLORS[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrapping linear counter with compare-based region decode.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned FRONT  = DEF_H_FRONT,
  parameter int unsigned PULSE  = DEF_H_PULSE,
  parameter int unsigned BACK   = DEF_H_BACK,
  parameter int unsigned CW     = 11
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_en,
  output logic [CW-1:0] o_count,
  output logic          o_first,
  output logic          o_active,
  output logic          o_pulse
);

  localparam int unsigned   TOTAL       = ACTIVE + FRONT + PULSE + BACK;
  localparam logic [CW-1:0] LAST        = CW'(TOTAL - 1);
  localparam logic [CW-1:0] ACT_END     = CW'(ACTIVE);
  localparam logic [CW-1:0] PULSE_START = CW'(ACTIVE + FRONT);
  localparam logic [CW-1:0] PULSE_END   = CW'(ACTIVE + FRONT + PULSE);
  localparam logic [CW-1:0] ONE         = CW'(1);

  logic [CW-1:0] r_count;

  // Position counter, wraps to zero after the back porch.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_en && (r_count == LAST)) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + ONE;
    end
  end

  assign o_count  = r_count;
  assign o_first  = (r_count == '0);
  assign o_active = (r_count < ACT_END);
  assign o_pulse  = (r_count >= PULSE_START) && (r_count < PULSE_END);

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster generator with a delay-matched pixel-fetch pipeline.
// Optional colour-bar source enabled by defining VGA_TIMING_TEST_PATTERN_EN.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = DEF_H_ACTIVE,
  parameter int unsigned H_FRONT   = DEF_H_FRONT,
  parameter int unsigned H_PULSE   = DEF_H_PULSE,
  parameter int unsigned H_BACK    = DEF_H_BACK,
  parameter int unsigned V_ACTIVE  = DEF_V_ACTIVE,
  parameter int unsigned V_FRONT   = DEF_V_FRONT,
  parameter int unsigned V_PULSE   = DEF_V_PULSE,
  parameter int unsigned V_BACK    = DEF_V_BACK,
  parameter bit          HSYNC_POL = 1'b0,
  parameter bit          VSYNC_POL = 1'b0,
  parameter int unsigned FETCH_LAT = 1,
  parameter int unsigned CW        = 11
) (
  input  logic          i_clock,
  input  logic          i_reset,
`ifdef VGA_TIMING_TEST_PATTERN_EN
  input  logic          i_pattern_en,
`endif
  input  logic [7:0]    i_color_in,
  output logic [CW-1:0] o_next_x,
  output logic [CW-1:0] o_next_y,
  output logic          o_next_valid,
  output logic          o_hsync,
  output logic          o_vsync,
  output logic [7:0]    o_red,
  output logic [7:0]    o_green,
  output logic [7:0]    o_blue,
  output logic          o_blank_n,
  output logic          o_sync,
  output logic          o_clk,
  output logic          o_line_start,
  output logic          o_frame_start
);

  localparam logic [CW-1:0] H_LAST = CW'(H_ACTIVE + H_FRONT + H_PULSE + H_BACK - 1);

  logic [CW-1:0] w_hc;
  logic [CW-1:0] w_vc;
  logic          w_h_first, w_h_active, w_h_pulse;
  logic          w_v_first, w_v_active, w_v_pulse;
  logic          w_h_wrap;
  logic          w_next_valid;
  vga_pipe_t     w_fetch;
  vga_pipe_t     w_tail;
  vga_pipe_t     r_dly [FETCH_LAT];
  logic [7:0]    w_pixel;

  logic          r_hsync, r_vsync, r_blank_n, r_line_start, r_frame_start;
  logic [7:0]    r_red, r_green, r_blue;

  assign w_h_wrap = (w_hc == H_LAST);

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FRONT(H_FRONT), .PULSE(H_PULSE), .BACK(H_BACK), .CW(CW)
  ) u_h_axis (
    .i_clk(i_clock), .i_reset(i_reset), .i_en(1'b1),
    .o_count(w_hc), .o_first(w_h_first), .o_active(w_h_active), .o_pulse(w_h_pulse)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FRONT(V_FRONT), .PULSE(V_PULSE), .BACK(V_BACK), .CW(CW)
  ) u_v_axis (
    .i_clk(i_clock), .i_reset(i_reset), .i_en(w_h_wrap),
    .o_count(w_vc), .o_first(w_v_first), .o_active(w_v_active), .o_pulse(w_v_pulse)
  );

  assign w_next_valid = w_h_active & w_v_active;
  assign o_next_valid = w_next_valid;
  assign o_next_x     = w_next_valid ? w_hc : '0;
  assign o_next_y     = w_next_valid ? w_vc : '0;

  assign w_fetch = '{hs: w_h_pulse, vs: w_v_pulse, valid: w_next_valid,
                     x0: w_h_first, y0: w_v_first};

  // Tag delay line: keeps sync/valid/strobe tags level with the returning colour.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int i = 0; i < FETCH_LAT; i++) begin
        r_dly[i] <= PIPE_IDLE;
      end
    end else begin
      r_dly[0] <= w_fetch;
      for (int i = 1; i < FETCH_LAT; i++) begin
        r_dly[i] <= r_dly[i-1];
      end
    end
  end

  assign w_tail = r_dly[FETCH_LAT-1];

`ifdef VGA_TIMING_TEST_PATTERN_EN
  logic [CW-1:0] r_xdly [FETCH_LAT];
  logic [CW+2:0] w_x8;
  logic [CW+2:0] w_bar_q;
  logic [2:0]    w_bar_idx;

  // Column delay line feeding the colour-bar index.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int i = 0; i < FETCH_LAT; i++) begin
        r_xdly[i] <= '0;
      end
    end else begin
      r_xdly[0] <= w_hc;
      for (int i = 1; i < FETCH_LAT; i++) begin
        r_xdly[i] <= r_xdly[i-1];
      end
    end
  end

  always_comb begin
    w_x8      = {r_xdly[FETCH_LAT-1], 3'b000};
    w_bar_q   = w_x8 / (CW+3)'(H_ACTIVE);
    w_bar_idx = w_bar_q[2:0];
  end
`endif

  // Pixel source select at the sampling stage.
  always_comb begin
    w_pixel = i_color_in;
`ifdef VGA_TIMING_TEST_PATTERN_EN
    if (i_pattern_en) begin
      w_pixel = bar_color(w_bar_idx);
    end else begin
      w_pixel = i_color_in;
    end
`endif
  end

  // Output register towards the DAC and connector.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_hsync       <= ~HSYNC_POL;
      r_vsync       <= ~VSYNC_POL;
      r_red         <= 8'h00;
      r_green       <= 8'h00;
      r_blue        <= 8'h00;
      r_blank_n     <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_hsync       <= w_tail.hs ? HSYNC_POL : ~HSYNC_POL;
      r_vsync       <= w_tail.vs ? VSYNC_POL : ~VSYNC_POL;
      r_blank_n     <= w_tail.valid;
      r_line_start  <= w_tail.valid & w_tail.x0;
      r_frame_start <= w_tail.valid & w_tail.x0 & w_tail.y0;
      if (w_tail.valid) begin
        {r_red, r_green, r_blue} <= rgb332_expand(w_pixel);
      end else begin
        {r_red, r_green, r_blue} <= 24'h000000;
      end
    end
  end

  assign o_hsync       = r_hsync;
  assign o_vsync       = r_vsync;
  assign o_red         = r_red;
  assign o_green       = r_green;
  assign o_blue        = r_blue;
  assign o_blank_n     = r_blank_n;
  assign o_line_start  = r_line_start;
  assign o_frame_start = r_frame_start;
  assign o_sync        = 1'b0;
  assign o_clk         = i_clock;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: three small-timing instances (FETCH_LAT 1/3/2, both sync polarities).
module tb_vga_timing_gen;

  localparam int HA = 8, HF = 2, HP = 3, HB = 2;
  localparam int VA = 4, VF = 1, VP = 2, VB = 1;
  localparam int HT = 15, FT = 120;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_sync(input int c, input int s, input int p, input logic pol);
    return (c >= s && c < s + p) ? pol : ~pol;
  endfunction

  // ---------------- instance A: FETCH_LAT=1, active-low syncs
  logic rst_a, nv_a, hs_a, vs_a, bn_a, sy_a, ck_a, ls_a, fs_a;
  logic [7:0] col_a, r_a, g_a, b_a;
  logic [10:0] nx_a, ny_a;

  vga_timing_gen #(.H_ACTIVE(HA), .H_FRONT(HF), .H_PULSE(HP), .H_BACK(HB),
                   .V_ACTIVE(VA), .V_FRONT(VF), .V_PULSE(VP), .V_BACK(VB),
                   .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .FETCH_LAT(1), .CW(11)) dut_a (
    .i_clock(clk), .i_reset(rst_a),
`ifdef VGA_TIMING_TEST_PATTERN_EN
    .i_pattern_en(1'b0),
`endif
    .i_color_in(col_a), .o_next_x(nx_a), .o_next_y(ny_a), .o_next_valid(nv_a),
    .o_hsync(hs_a), .o_vsync(vs_a), .o_red(r_a), .o_green(g_a), .o_blue(b_a),
    .o_blank_n(bn_a), .o_sync(sy_a), .o_clk(ck_a),
    .o_line_start(ls_a), .o_frame_start(fs_a));

  // ---------------- instance B: FETCH_LAT=3, colour echoes the column
  logic rst_b, nv_b, hs_b, vs_b, bn_b, sy_b, ck_b, ls_b, fs_b;
  logic [7:0] col_b, r_b, g_b, b_b;
  logic [10:0] nx_b, ny_b;
  logic [10:0] eb1, eb2, eb3;

  always_ff @(posedge clk) begin
    eb1 <= nx_b;
    eb2 <= eb1;
    eb3 <= eb2;
  end
  assign col_b = {eb3[2:0], 5'b00000};

  vga_timing_gen #(.H_ACTIVE(HA), .H_FRONT(HF), .H_PULSE(HP), .H_BACK(HB),
                   .V_ACTIVE(VA), .V_FRONT(VF), .V_PULSE(VP), .V_BACK(VB),
                   .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .FETCH_LAT(3), .CW(11)) dut_b (
    .i_clock(clk), .i_reset(rst_b),
`ifdef VGA_TIMING_TEST_PATTERN_EN
    .i_pattern_en(1'b0),
`endif
    .i_color_in(col_b), .o_next_x(nx_b), .o_next_y(ny_b), .o_next_valid(nv_b),
    .o_hsync(hs_b), .o_vsync(vs_b), .o_red(r_b), .o_green(g_b), .o_blue(b_b),
    .o_blank_n(bn_b), .o_sync(sy_b), .o_clk(ck_b),
    .o_line_start(ls_b), .o_frame_start(fs_b));

  // ---------------- instance C: FETCH_LAT=2, active-high syncs
  logic rst_c, nv_c, hs_c, vs_c, bn_c, sy_c, ck_c, ls_c, fs_c;
  logic [7:0] col_c, r_c, g_c, b_c;
  logic [10:0] nx_c, ny_c;

  vga_timing_gen #(.H_ACTIVE(HA), .H_FRONT(HF), .H_PULSE(HP), .H_BACK(HB),
                   .V_ACTIVE(VA), .V_FRONT(VF), .V_PULSE(VP), .V_BACK(VB),
                   .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .FETCH_LAT(2), .CW(11)) dut_c (
    .i_clock(clk), .i_reset(rst_c),
`ifdef VGA_TIMING_TEST_PATTERN_EN
    .i_pattern_en(1'b0),
`endif
    .i_color_in(col_c), .o_next_x(nx_c), .o_next_y(ny_c), .o_next_valid(nv_c),
    .o_hsync(hs_c), .o_vsync(vs_c), .o_red(r_c), .o_green(g_c), .o_blue(b_c),
    .o_blank_n(bn_c), .o_sync(sy_c), .o_clk(ck_c),
    .o_line_start(ls_c), .o_frame_start(fs_c));

  // colour input per frame and its hand-expanded DAC values
  logic [7:0] cin_t [3] = '{8'hE0, 8'h03, 8'h49};
  logic [7:0] red_t [3] = '{8'hFF, 8'h00, 8'h49};
  logic [7:0] grn_t [3] = '{8'h00, 8'h00, 8'h49};
  logic [7:0] blu_t [3] = '{8'h00, 8'hFF, 8'h55};

  int h, v, j, jh, jv, n, partial;
  logic vis, jvis, found;

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    col_a = cin_t[0]; col_c = 8'h03;
    repeat (5) @(posedge clk);
    #1;
    check_val("a_rst_hsync", hs_a, 1);
    check_val("a_rst_vsync", vs_a, 1);
    check_val("a_rst_rgb", {r_a, g_a, b_a}, 0);
    check_val("a_rst_blank_n", bn_a, 0);
    check_val("a_rst_strobes", {ls_a, fs_a}, 0);
    check_val("a_sync_tied", sy_a, 0);
    check_val("a_clk_fwd", ck_a, clk);
    check_val("c_rst_hsync", hs_c, 0);
    check_val("c_rst_vsync", vs_c, 0);

    // ---- A: release, first fetch, first frame_start
    @(negedge clk);
    rst_a = 1'b0;
    #1;
    check_val("a_first_valid", nv_a, 1);
    check_val("a_first_xy", {nx_a, ny_a}, 0);
    n = 0; found = 1'b0;
    for (int k = 1; k <= 8 && !found; k++) begin
      @(posedge clk); #1;
      if (fs_a) begin found = 1'b1; n = k; end
    end
    check_val("a_fs_latency", n, 2);

    // ---- A: three whole frames, one colour each
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < FT; i++) begin
        h = i % HT; v = i / HT; vis = (h < HA) && (v < VA);
        j = (i + 2) % FT; jh = j % HT; jv = j / HT; jvis = (jh < HA) && (jv < VA);
        check_val("a_hsync", hs_a, exp_sync(h, HA + HF, HP, 1'b0));
        check_val("a_vsync", vs_a, exp_sync(v, VA + VF, VP, 1'b0));
        check_val("a_blank_n", bn_a, vis);
        check_val("a_line_start", ls_a, vis && h == 0);
        check_val("a_frame_start", fs_a, i == 0);
        check_val("a_red", r_a, vis ? red_t[f] : 8'h00);
        check_val("a_green", g_a, vis ? grn_t[f] : 8'h00);
        check_val("a_blue", b_a, vis ? blu_t[f] : 8'h00);
        check_val("a_next_valid", nv_a, jvis);
        check_val("a_next_x", nx_a, jvis ? jh : 0);
        check_val("a_next_y", ny_a, jvis ? jv : 0);
        if (i == 100 && f < 2) col_a = cin_t[f+1];
        @(posedge clk); #1;
      end
    end
    check_val("a_frame_period", fs_a, 1);

    // ---- B: release, latency, x echo on line 0
    @(negedge clk);
    rst_b = 1'b0;
    n = 0; found = 1'b0;
    for (int k = 1; k <= 10 && !found; k++) begin
      @(posedge clk); #1;
      if (fs_b) begin found = 1'b1; n = k; end
    end
    check_val("b_fs_latency", n, 4);
    for (int k = 0; k <= HA; k++) begin
      check_val("b_blank_n", bn_b, k < HA);
      check_val("b_red_echo", r_b, (k < HA) ? {k[2:0], k[2:0], k[2:1]} : 8'h00);
      @(posedge clk); #1;
    end

    // ---- B: reset while fetching (5,2)
    found = 1'b0;
    for (int k = 0; k < 2 * FT && !found; k++) begin
      if (nv_b && nx_b == 11'd5 && ny_b == 11'd2) found = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check_val("b_find_5_2", found, 1);
    check_val("b_pre_rst_blank_n", bn_b, 1);
    rst_b = 1'b1;
    @(posedge clk); #1;
    check_val("b_midrst_blank_n", bn_b, 0);
    check_val("b_midrst_syncs", {hs_b, vs_b}, 2'b11);
    check_val("b_midrst_rgb", {r_b, g_b, b_b}, 0);
    check_val("b_midrst_strobes", {ls_b, fs_b}, 0);
    @(negedge clk);
    rst_b = 1'b0;
    n = 0; found = 1'b0; partial = 0;
    for (int k = 1; k <= 10 && !found; k++) begin
      @(posedge clk); #1;
      if (ls_b && !fs_b) partial++;
      if (fs_b) begin found = 1'b1; n = k; end
    end
    check_val("b_midrst_fs_latency", n, 4);
    check_val("b_midrst_partial", partial, 0);

    // ---- C: active-high syncs over one frame
    @(negedge clk);
    rst_c = 1'b0;
    n = 0; found = 1'b0;
    for (int k = 1; k <= 10 && !found; k++) begin
      @(posedge clk); #1;
      if (fs_c) begin found = 1'b1; n = k; end
    end
    check_val("c_fs_latency", n, 3);
    for (int i = 0; i < FT; i++) begin
      h = i % HT; v = i / HT; vis = (h < HA) && (v < VA);
      check_val("c_hsync", hs_c, exp_sync(h, HA + HF, HP, 1'b1));
      check_val("c_vsync", vs_c, exp_sync(v, VA + VF, VP, 1'b1));
      check_val("c_blank_n", bn_c, vis);
      check_val("c_blue", b_c, vis ? 8'hFF : 8'h00);
      @(posedge clk); #1;
    end
    check_val("c_frame_period", fs_c, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
